decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter IW, default 8, instruction word width (IW >= 2*RW+4).
REQ-002 SHALL have parameter NREG, default 4, register count (power of two); RW = clog2(NREG).
REQ-003 SHALL have parameter CW, default 16, decode-counter width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, as already decided.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_instr  in  IW  instruction or immediate word.
REQ-008 in_valid / in_ready  in / out  1  input handshake.
REQ-009 force_nop  in  1  squash the word accepted this cycle.
REQ-010 out_valid / out_ready  out / in  1  output handshake.
REQ-011 rs_read, rt_read  out  RW  source register selects.
REQ-012 is_write  out  1; reg_write  out  NREG  one-hot write enable.
REQ-013 is_short_imm, is_jump, is_load_next  out  1  class flags.
REQ-014 alu_op  out  IW-1-2*RW  ALU operation; imm  out  IW  zero-extended immediate.
REQ-015 imm_pending  out  1  high in S_IMM; decode_count  out  CW  emitted-result count.

Function
REQ-016 Transfer SHALL occur when valid and ready are both high on a rising edge.
REQ-017 in_ready SHALL equal !out_valid || out_ready, giving full throughput and a single output register.
REQ-018 Class SHALL be instr[IW-1:IW-2]: 0x = ALU, 10 = immediate, 11 = jump.
REQ-019 ALU: alu_op = instr[IW-2:2*RW], rs = instr[2RW-1:RW], rt = instr[RW-1:0], is_write=1, reg_write = onehot(rs).
REQ-020 Immediate, low field instr[IW-3-RW:0] nonzero: is_short_imm=1, dest = instr[IW-3 -: RW] on rs_read, imm = low field, is_write=1.
REQ-021 Immediate, low field zero: load-next; the word SHALL be absorbed with no output, and the FSM moves S_DECODE -> S_IMM latching dest.
REQ-022 In S_IMM, the next accepted word SHALL be the raw immediate; emit is_load_next=1, imm = word, rs_read = dest, reg_write = onehot(dest), then return to S_DECODE.
REQ-023 Jump: is_jump=1, imm = instr[IW-3:0], is_write=0.
REQ-024 Each emitted result SHALL appear on the outputs the cycle after acceptance, with latency 1.
REQ-025 Unused fields SHALL be 0; alu_op SHALL be 0 for non-ALU classes.
REQ-026 force_nop with an accepted word SHALL emit a NOP: out_valid=1 and all flags, reg_write, and imm equal to 0.
REQ-027 A squashed load-next in S_DECODE SHALL emit a NOP and not enter S_IMM.
REQ-028 force_nop in S_IMM SHALL consume the word, emit a NOP, and return to S_DECODE.
REQ-029 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-030 decode_count SHALL increment once per emitted result, including NOPs, and wrap from 2^CW-1 to 0.
REQ-031 force_nop without an accepted word SHALL have no effect.

Reset
REQ-032 rst SHALL force S_DECODE, out_valid=0, decode_count=0, and all decode outputs to 0 immediately.
REQ-033 Reset in S_IMM SHALL discard the pending load-next; the first word after reset SHALL decode as an instruction.

Structure
REQ-034 Class codes, FSM state encoding, and the NOP constant SHALL reside in shared package decode_pkg.
REQ-035 Field extraction SHALL be a combinational sub-module, decode_fields; decode_stage adds the FSM, the output register, and the counter.

Verification (IW=8, NREG=4)
REQ-036 0x1B, out_ready=1 -> next cycle alu_op=001, rs=2, rt=3, reg_write=0100, is_write=1, decode_count=1.
REQ-037 0x80 then 0x5A -> no output for 0x80, imm_pending=1; then is_load_next=1, imm=0x5A, reg_write=0001, imm_pending=0.
REQ-038 0xC5 -> is_jump=1, imm=0x05, is_write=0; 0x93 -> is_short_imm=1, rs=1, imm=0x03, reg_write=0010.
REQ-039 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no words lost after release.
REQ-040 0x80 then 0x44 with force_nop -> NOP emitted, S_DECODE; 0x80 then rst -> next 0x1B decodes as ALU.
REQ-041 Preload decode_count=0xFFFF by 65535 emits -> next emit reads 0x0000.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction class codes, FSM states,
// output flag bundle and the NOP flag constant.
package decode_pkg;

    typedef enum logic [1:0] {
        CLS_ALU0 = 2'b00,
        CLS_ALU1 = 2'b01,
        CLS_IMM  = 2'b10,
        CLS_JMP  = 2'b11
    } cls_e;

    typedef enum logic {
        S_DECODE = 1'b0,
        S_IMM    = 1'b1
    } state_e;

    typedef struct packed {
        logic is_write;
        logic is_short_imm;
        logic is_jump;
        logic is_load_next;
    } flags_t;

    localparam flags_t NOP_FLAGS = '0;

endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction from one instruction word.
// Ports: instr in; cls, alu_op, rs, rt, dest, low_zero, low_imm, jmp_imm out.
module decode_fields #(
    parameter int IW   = 8,
    parameter int NREG = 4,
    localparam int RW  = $clog2(NREG),
    localparam int AW  = IW - 1 - 2 * RW,
    localparam int LW  = IW - 2 - RW
) (
    input  logic [IW-1:0] instr,
    output logic [1:0]    cls,
    output logic [AW-1:0] alu_op,
    output logic [RW-1:0] rs,
    output logic [RW-1:0] rt,
    output logic [RW-1:0] dest,
    output logic          low_zero,
    output logic [IW-1:0] low_imm,
    output logic [IW-1:0] jmp_imm
);

    assign cls      = instr[IW-1:IW-2];
    assign alu_op   = instr[IW-2:2*RW];
    assign rs       = instr[2*RW-1:RW];
    assign rt       = instr[RW-1:0];
    assign dest     = instr[IW-3 -: RW];
    assign low_zero = (instr[LW-1:0] == '0);
    assign low_imm  = IW'(instr[LW-1:0]);
    assign jmp_imm  = IW'(instr[IW-3:0]);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: valid/ready pipeline register with a two-word load-next FSM.
// Ports: clk, rst, in_* handshake, force_nop, out_* handshake, decoded fields.
module decode_stage
    import decode_pkg::*;
#(
    parameter int IW   = 8,
    parameter int NREG = 4,
    parameter int CW   = 16,
    localparam int RW  = $clog2(NREG),
    localparam int AW  = IW - 1 - 2 * RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   in_instr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            force_nop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   rs_read,
    output logic [RW-1:0]   rt_read,
    output logic            is_write,
    output logic [NREG-1:0] reg_write,
    output logic            is_short_imm,
    output logic            is_jump,
    output logic            is_load_next,
    output logic [AW-1:0]   alu_op,
    output logic [IW-1:0]   imm,
    output logic            imm_pending,
    output logic [CW-1:0]   decode_count
);

    logic [1:0]    f_cls;
    logic [AW-1:0] f_alu_op;
    logic [RW-1:0] f_rs;
    logic [RW-1:0] f_rt;
    logic [RW-1:0] f_dest;
    logic          f_low_zero;
    logic [IW-1:0] f_low_imm;
    logic [IW-1:0] f_jmp_imm;

    decode_fields #(
        .IW   (IW),
        .NREG (NREG)
    ) u_fields (
        .instr    (in_instr),
        .cls      (f_cls),
        .alu_op   (f_alu_op),
        .rs       (f_rs),
        .rt       (f_rt),
        .dest     (f_dest),
        .low_zero (f_low_zero),
        .low_imm  (f_low_imm),
        .jmp_imm  (f_jmp_imm)
    );

    state_e        state;
    state_e        state_d;
    logic [RW-1:0] dest_q;
    logic [RW-1:0] dest_d;

    logic            accept;
    logic            emit;
    flags_t          n_flags;
    logic [RW-1:0]   n_rs;
    logic [RW-1:0]   n_rt;
    logic [AW-1:0]   n_alu_op;
    logic [IW-1:0]   n_imm;
    logic [NREG-1:0] n_reg_write;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign imm_pending = (state == S_IMM);

    always_comb begin
        state_d  = state;
        dest_d   = dest_q;
        emit     = 1'b0;
        n_flags  = NOP_FLAGS;
        n_rs     = '0;
        n_rt     = '0;
        n_alu_op = '0;
        n_imm    = '0;
        if (accept) begin
            if (force_nop) begin
                // Squash always lands back in S_DECODE, even mid load-next.
                emit    = 1'b1;
                state_d = S_DECODE;
            end else if (state == S_IMM) begin
                emit                 = 1'b1;
                n_flags.is_load_next = 1'b1;
                n_flags.is_write     = 1'b1;
                n_rs                 = dest_q;
                n_imm                = in_instr;
                state_d              = S_DECODE;
            end else begin
                unique case (cls_e'(f_cls))
                    CLS_ALU0, CLS_ALU1: begin
                        emit             = 1'b1;
                        n_flags.is_write = 1'b1;
                        n_alu_op         = f_alu_op;
                        n_rs             = f_rs;
                        n_rt             = f_rt;
                    end
                    CLS_IMM: begin
                        if (f_low_zero) begin
                            // Zero short field: payload is the next word.
                            state_d = S_IMM;
                            dest_d  = f_dest;
                        end else begin
                            emit                 = 1'b1;
                            n_flags.is_write     = 1'b1;
                            n_flags.is_short_imm = 1'b1;
                            n_rs                 = f_dest;
                            n_imm                = f_low_imm;
                        end
                    end
                    CLS_JMP: begin
                        emit            = 1'b1;
                        n_flags.is_jump = 1'b1;
                        n_imm           = f_jmp_imm;
                    end
                endcase
            end
        end
        // Every writing class targets the register carried on rs_read.
        n_reg_write = n_flags.is_write ? (NREG'(1) << n_rs) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_DECODE;
            dest_q       <= '0;
            out_valid    <= 1'b0;
            rs_read      <= '0;
            rt_read      <= '0;
            is_write     <= 1'b0;
            reg_write    <= '0;
            is_short_imm <= 1'b0;
            is_jump      <= 1'b0;
            is_load_next <= 1'b0;
            alu_op       <= '0;
            imm          <= '0;
            decode_count <= '0;
        end else begin
            state  <= state_d;
            dest_q <= dest_d;
            if (emit) begin
                out_valid    <= 1'b1;
                rs_read      <= n_rs;
                rt_read      <= n_rt;
                is_write     <= n_flags.is_write;
                reg_write    <= n_reg_write;
                is_short_imm <= n_flags.is_short_imm;
                is_jump      <= n_flags.is_jump;
                is_load_next <= n_flags.is_load_next;
                alu_op       <= n_alu_op;
                imm          <= n_imm;
                decode_count <= decode_count + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage (IW=8, NREG=4, CW=16).
// Vector table plus hand sequences; expected results go through a queue.
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_instr = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       force_nop = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] rs_read;
    logic [1:0] rt_read;
    logic       is_write;
    logic [3:0] reg_write;
    logic       is_short_imm;
    logic       is_jump;
    logic       is_load_next;
    logic [2:0] alu_op;
    logic [7:0] imm;
    logic       imm_pending;
    logic [15:0] decode_count;

    decode_stage #(.IW(8), .NREG(4), .CW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .force_nop    (force_nop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rs_read      (rs_read),
        .rt_read      (rt_read),
        .is_write     (is_write),
        .reg_write    (reg_write),
        .is_short_imm (is_short_imm),
        .is_jump      (is_jump),
        .is_load_next (is_load_next),
        .alu_op       (alu_op),
        .imm          (imm),
        .imm_pending  (imm_pending),
        .decode_count (decode_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [2:0]  alu;
        logic [7:0]  imm;
        logic [3:0]  rw;
        logic        w;
        logic        sh;
        logic        j;
        logic        ld;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] word;
        bit         nop;
        bit         has;
        bit         pend;
        exp_t       e;
    } row_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q[$];
    bit          m_ov = 1'b0;
    logic [15:0] m_cnt = '0;
    row_t        tbl[16];
    exp_t        snap;
    exp_t        nop_e;
    bit          acc;

    function automatic exp_t mk(logic [1:0] rs, logic [1:0] rt,
                                logic [2:0] alu, logic [7:0] im,
                                logic [3:0] rw, logic w, logic sh,
                                logic j, logic ld);
        exp_t e;
        e.rs  = rs;
        e.rt  = rt;
        e.alu = alu;
        e.imm = im;
        e.rw  = rw;
        e.w   = w;
        e.sh  = sh;
        e.j   = j;
        e.ld  = ld;
        e.cnt = '0;
        return e;
    endfunction

    function automatic exp_t act();
        exp_t e;
        e.rs  = rs_read;
        e.rt  = rt_read;
        e.alu = alu_op;
        e.imm = imm;
        e.rw  = reg_write;
        e.w   = is_write;
        e.sh  = is_short_imm;
        e.j   = is_jump;
        e.ld  = is_load_next;
        e.cnt = decode_count;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // One clock: drive at negedge, check/score at negedge+1.
    task automatic cyc(input bit v, input logic [7:0] w, input bit n,
                       input bit r, input bit has, input exp_t e,
                       output bit a);
        exp_t x;
        @(negedge clk);
        in_valid  = v;
        in_instr  = w;
        force_nop = n;
        out_ready = r;
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("in_ready", 64'(in_ready), 64'(!m_ov || r));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %h want none", act());
            end else begin
                x = q.pop_front();
                chk("out_fields", 64'(act()), 64'(x));
            end
        end
        a = v && (!m_ov || r);
        if (a && has) begin
            m_cnt++;
            x     = e;
            x.cnt = m_cnt;
            q.push_back(x);
        end
        m_ov = (a && has) ? 1'b1 : (r ? 1'b0 : m_ov);
        @(posedge clk);
    endtask

    task automatic send(input logic [7:0] w, input bit n, input bit has,
                        input exp_t e);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 20 && !a; k++) cyc(1'b1, w, n, 1'b1, has, e, a);
        if (!a) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got not_accepted want accepted");
        end
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 10 && (q.size() != 0 || m_ov); k++)
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, nop_e, a);
        chk("drain_q", 64'(q.size()), 64'd0);
    endtask

    initial begin
        nop_e = mk(0, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 0);

        tbl[0]  = '{8'h1B, 0, 1, 0, mk(2, 3, 3'b001, 8'h00, 4'b0100, 1, 0, 0, 0)};
        tbl[1]  = '{8'h80, 0, 0, 1, nop_e};
        tbl[2]  = '{8'h5A, 0, 1, 0, mk(0, 0, 0, 8'h5A, 4'b0001, 1, 0, 0, 1)};
        tbl[3]  = '{8'hC5, 0, 1, 0, mk(0, 0, 0, 8'h05, 4'b0000, 0, 0, 1, 0)};
        tbl[4]  = '{8'h93, 0, 1, 0, mk(1, 0, 0, 8'h03, 4'b0010, 1, 1, 0, 0)};
        tbl[5]  = '{8'h00, 0, 1, 0, mk(0, 0, 0, 8'h00, 4'b0001, 1, 0, 0, 0)};
        tbl[6]  = '{8'h7F, 0, 1, 0, mk(3, 3, 3'b111, 8'h00, 4'b1000, 1, 0, 0, 0)};
        tbl[7]  = '{8'hB0, 0, 0, 1, nop_e};
        tbl[8]  = '{8'hFF, 0, 1, 0, mk(3, 0, 0, 8'hFF, 4'b1000, 1, 0, 0, 1)};
        tbl[9]  = '{8'h80, 0, 0, 1, nop_e};
        tbl[10] = '{8'h44, 1, 1, 0, nop_e};
        tbl[11] = '{8'h1B, 1, 1, 0, nop_e};
        tbl[12] = '{8'h80, 1, 1, 0, nop_e};
        tbl[13] = '{8'h5A, 0, 1, 0, mk(2, 2, 3'b101, 8'h00, 4'b0100, 1, 0, 0, 0)};
        tbl[14] = '{8'hFF, 0, 1, 0, mk(0, 0, 0, 8'h3F, 4'b0000, 0, 0, 1, 0)};
        tbl[15] = '{8'hBF, 0, 1, 0, mk(3, 0, 0, 8'h0F, 4'b1000, 1, 1, 0, 0)};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(decode_count), 64'd0);
        chk("rst_fields", 64'(act()), 64'(nop_e));
        chk("rst_pending", 64'(imm_pending), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            send(tbl[i].word, tbl[i].nop, tbl[i].has, tbl[i].e);
            #1;
            chk($sformatf("pending[%0d]", i), 64'(imm_pending),
                64'(tbl[i].pend));
        end
        drain();

        // Idle force_nop while a load-next is pending changes nothing.
        send(8'h90, 0, 0, nop_e);
        cyc(1'b0, 8'h33, 1'b1, 1'b1, 1'b0, nop_e, acc);
        #1;
        chk("idle_nop_pending", 64'(imm_pending), 64'd1);
        send(8'h21, 0, 1, mk(1, 0, 0, 8'h21, 4'b0010, 1, 0, 0, 1));
        drain();

        // Backpressure: output held, input stalled, nothing lost.
        cyc(1'b1, 8'h1B, 1'b0, 1'b0, 1'b1,
            mk(2, 3, 3'b001, 8'h00, 4'b0100, 1, 0, 0, 0), acc);
        #1;
        snap = act();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'hC5, 1'b0, 1'b0, 1'b1,
                mk(0, 0, 0, 8'h05, 4'b0000, 0, 0, 1, 0), acc);
            #1;
            chk("stall_hold", 64'(act()), 64'(snap));
            chk("stall_acc", 64'(acc), 64'd0);
        end
        cyc(1'b1, 8'hC5, 1'b0, 1'b1, 1'b1,
            mk(0, 0, 0, 8'h05, 4'b0000, 0, 0, 1, 0), acc);
        chk("release_acc", 64'(acc), 64'd1);
        drain();

        // Reset while a load-next is pending.
        send(8'h80, 0, 0, nop_e);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("async_rst_pending", 64'(imm_pending), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_fields", 64'(act()), 64'(nop_e));
        m_ov  = 1'b0;
        m_cnt = '0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(8'h1B, 0, 1, mk(2, 3, 3'b001, 8'h00, 4'b0100, 1, 0, 0, 0));
        drain();

        // Counter wrap.
        while (m_cnt != 16'hFFFF)
            cyc(1'b1, 8'hC5, 1'b0, 1'b1, 1'b1,
                mk(0, 0, 0, 8'h05, 4'b0000, 0, 0, 1, 0), acc);
        drain();
        chk("count_full", 64'(decode_count), 64'hFFFF);
        send(8'h93, 0, 1, mk(1, 0, 0, 8'h03, 4'b0010, 1, 1, 0, 0));
        drain();
        chk("count_wrap", 64'(decode_count), 64'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
